// File: rtl/reset_sequencer_if.sv
// Reset sequencer board-side bundle: pushbutton request in, sequenced resets and debug status out.
// The sequencer takes the master modport; the consumer (board glue or bench) takes the slave modport.
interface reset_sequencer_if;
  logic       btn_n;
  logic       sys_reset_n;
  logic       core_reset_n;
  logic [1:0] seq_state;
  logic [7:0] reset_count;

  modport master (
    input  btn_n,
    output sys_reset_n,
    output core_reset_n,
    output seq_state,
    output reset_count
  );

  modport slave (
    output btn_n,
    input  sys_reset_n,
    input  core_reset_n,
    input  seq_state,
    input  reset_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// Merges global reset with a debounced pushbutton, stretches sys_reset_n, then delays core_reset_n for clock settle.
// Button to reset latency is 2 sync + DEBOUNCE_CYCLES + 1 edges; all outputs come straight from flops.
module reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 8,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  reset_sequencer_if.master rs
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W = (STRETCH_CYCLES  > 1) ? $clog2(STRETCH_CYCLES)  : 1;
  localparam int SE_W = (SETTLE_CYCLES   > 1) ? $clog2(SETTLE_CYCLES)   : 1;
  localparam int SQ_W = (ST_W > SE_W) ? ST_W : SE_W;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SQ_W-1:0] ST_LAST = SQ_W'(STRETCH_CYCLES - 1);
  localparam logic [SQ_W-1:0] SE_LAST = SQ_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    SETTLE  = 2'd2,
    RUN     = 2'd3
  } state_t;

  logic            btn_meta;
  logic            btn_s;
  logic            deb_level;
  logic [DB_W-1:0] deb_cnt;

  state_t          state;
  state_t          state_nxt;
  logic [SQ_W-1:0] seq_cnt;
  logic [SQ_W-1:0] seq_cnt_nxt;
  logic [7:0]      count_q;
  logic [7:0]      count_nxt;
  logic            sys_q;
  logic            sys_nxt;
  logic            core_q;
  logic            core_nxt;

  // Synchronizer idles at 1 so a held reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= 1'b1;
      btn_s    <= 1'b1;
    end else begin
      btn_meta <= rs.btn_n;
      btn_s    <= btn_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (btn_s != deb_level) begin
      if (deb_cnt == DB_LAST) begin
        deb_level <= btn_s;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    seq_cnt_nxt = seq_cnt;
    count_nxt   = count_q;
    sys_nxt     = 1'b0;
    core_nxt    = 1'b0;

    // A held button overrides every state, so STRETCH/SETTLE progress is simply dropped.
    if (!deb_level) begin
      state_nxt   = HOLD;
      seq_cnt_nxt = '0;
    end else begin
      case (state)
        HOLD: begin
          state_nxt   = STRETCH;
          seq_cnt_nxt = '0;
        end
        STRETCH: begin
          if (seq_cnt == ST_LAST) begin
            state_nxt   = SETTLE;
            seq_cnt_nxt = '0;
          end else begin
            seq_cnt_nxt = seq_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (seq_cnt == SE_LAST) begin
            state_nxt   = RUN;
            seq_cnt_nxt = '0;
          end else begin
            seq_cnt_nxt = seq_cnt + 1'b1;
          end
        end
        RUN: begin
          seq_cnt_nxt = '0;
        end
        default: begin
          state_nxt   = HOLD;
          seq_cnt_nxt = '0;
        end
      endcase
    end

    if ((state_nxt == HOLD) && (state != HOLD) && (count_q != 8'hFF)) begin
      count_nxt = count_q + 8'd1;
    end

    sys_nxt  = (state_nxt == SETTLE) || (state_nxt == RUN);
    core_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= STRETCH;
      seq_cnt <= '0;
      count_q <= 8'd0;
      sys_q   <= 1'b0;
      core_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      seq_cnt <= seq_cnt_nxt;
      count_q <= count_nxt;
      sys_q   <= sys_nxt;
      core_q  <= core_nxt;
    end
  end

  assign rs.sys_reset_n  = sys_q;
  assign rs.core_reset_n = core_q;
  assign rs.seq_state    = state;
  assign rs.reset_count  = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a short-debounce instance that can reach SETTLE with a press.
module tb_reset_sequencer;
  localparam int DEB  = 16;
  localparam int STR  = 8;
  localparam int SET  = 4;
  localparam int FDEB = 4;

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  typedef struct {
    int         at;
    bit         fast;
    logic       sys;
    logic       core;
    logic [1:0] st;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reset_sequencer_if bus ();
  reset_sequencer_if fbus ();

  reset_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR), .SETTLE_CYCLES(SET)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .rs(bus.master)
  );

  reset_sequencer #(
    .DEBOUNCE_CYCLES(FDEB), .STRETCH_CYCLES(STR), .SETTLE_CYCLES(SET)
  ) u_fast (
    .clk(clk), .reset_n(reset_n), .rs(fbus.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at_cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int at, input bit fast, input logic [1:0] st,
                      input logic [7:0] cnt, input string tag);
    exp_t e;
    e.at   = at;
    e.fast = fast;
    e.st   = st;
    e.sys  = (st == S_SETTLE) || (st == S_RUN);
    e.core = (st == S_RUN);
    e.cnt  = cnt;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Scoreboard pops every expectation due at this edge; late entries count as misses.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        check({e.tag, "_missed"}, cyc, e.at);
      end else if (e.fast) begin
        check({e.tag, "_sys"},   fbus.sys_reset_n,  e.sys);
        check({e.tag, "_core"},  fbus.core_reset_n, e.core);
        check({e.tag, "_state"}, fbus.seq_state,    e.st);
        check({e.tag, "_count"}, fbus.reset_count,  e.cnt);
      end else begin
        check({e.tag, "_sys"},   bus.sys_reset_n,  e.sys);
        check({e.tag, "_core"},  bus.core_reset_n, e.core);
        check({e.tag, "_state"}, bus.seq_state,    e.st);
        check({e.tag, "_count"}, bus.reset_count,  e.cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic release_reset(output int rel);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    rel = cyc;
  endtask

  task automatic power_on_exp(input int rel, input string tag);
    for (int i = 0; i < 2; i++) begin
      push(rel + 1,             bit'(i), S_STRETCH, 8'd0, {tag, "_e1"});
    end
    for (int i = 0; i < 2; i++) begin
      push(rel + STR - 1,       bit'(i), S_STRETCH, 8'd0, {tag, "_str_last"});
    end
    for (int i = 0; i < 2; i++) begin
      push(rel + STR,           bit'(i), S_SETTLE,  8'd0, {tag, "_sys_up"});
    end
    for (int i = 0; i < 2; i++) begin
      push(rel + STR + SET - 1, bit'(i), S_SETTLE,  8'd0, {tag, "_set_last"});
    end
    for (int i = 0; i < 2; i++) begin
      push(rel + STR + SET,     bit'(i), S_RUN,     8'd0, {tag, "_core_up"});
    end
  endtask

  // Press the main instance's button from RUN and follow it through the full recovery.
  task automatic press(input int low, input int k, input string tag);
    int f;
    int r;
    logic [7:0] c;
    c = (k >= 255) ? 8'd255 : 8'(k + 1);
    tick(1);
    f = cyc;
    bus.btn_n = 1'b0;
    push(f + DEB + 2, 1'b0, S_RUN,  8'(k), {tag, "_pre"});
    push(f + DEB + 3, 1'b0, S_HOLD, c,     {tag, "_hold"});
    tick(low);
    r = cyc;
    bus.btn_n = 1'b1;
    push(r + DEB + 2,             1'b0, S_HOLD,    c, {tag, "_hold_last"});
    push(r + DEB + 3,             1'b0, S_STRETCH, c, {tag, "_stretch"});
    push(r + DEB + 3 + STR - 1,   1'b0, S_STRETCH, c, {tag, "_str_last"});
    push(r + DEB + 3 + STR,       1'b0, S_SETTLE,  c, {tag, "_sys_up"});
    push(r + DEB + 3 + STR + SET - 1, 1'b0, S_SETTLE, c, {tag, "_set_last"});
    push(r + DEB + 3 + STR + SET, 1'b0, S_RUN,     c, {tag, "_core_up"});
    drain(200);
  endtask

  task automatic bounce(input int k);
    int s;
    int lens[3] = '{1, 5, 15};
    tick(1);
    s = cyc;
    for (int i = 1; i <= 10; i++) push(s + 5 * i, 1'b0, S_RUN, 8'(k), "bounce");
    for (int i = 0; i < 3; i++) begin
      bus.btn_n = 1'b0;
      tick(lens[i]);
      bus.btn_n = 1'b1;
      tick(3);
    end
    drain(100);
  endtask

  // Second press lands so the debounced level falls while the fast instance sits in SETTLE.
  task automatic fast_settle();
    int f;
    int r;
    int f2;
    int r2;
    tick(1);
    f = cyc;
    fbus.btn_n = 1'b0;
    push(f + FDEB + 3, 1'b1, S_HOLD, 8'd1, "fs_hold1");
    tick(10);
    r = cyc;
    fbus.btn_n = 1'b1;
    push(r + FDEB + 3,       1'b1, S_STRETCH, 8'd1, "fs_stretch");
    push(r + FDEB + 3 + STR, 1'b1, S_SETTLE,  8'd1, "fs_settle");
    tick(10);
    f2 = cyc;
    fbus.btn_n = 1'b0;
    push(f2 + FDEB + 2, 1'b1, S_SETTLE, 8'd1, "fs_settle_last");
    push(f2 + FDEB + 3, 1'b1, S_HOLD,   8'd2, "fs_hold2");
    tick(30);
    r2 = cyc;
    fbus.btn_n = 1'b1;
    push(r2 + FDEB + 3,             1'b1, S_STRETCH, 8'd2, "fs_re_stretch");
    push(r2 + FDEB + 3 + STR - 1,   1'b1, S_STRETCH, 8'd2, "fs_re_str_last");
    push(r2 + FDEB + 3 + STR,       1'b1, S_SETTLE,  8'd2, "fs_re_sys_up");
    push(r2 + FDEB + 3 + STR + SET, 1'b1, S_RUN,     8'd2, "fs_re_core_up");
    drain(200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at_cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int k;
    bus.btn_n  = 1'b1;
    fbus.btn_n = 1'b1;
    reset_n    = 1'b0;
    #100;
    check("rst_sys",   bus.sys_reset_n,  1'b0);
    check("rst_core",  bus.core_reset_n, 1'b0);
    check("rst_state", bus.seq_state,    S_STRETCH);
    check("rst_count", bus.reset_count,  8'd0);

    release_reset(rel);
    power_on_exp(rel, "por");
    drain(100);

    press(40, 0, "press1");
    bounce(1);
    fast_settle();
    press(40, 1, "press2");
    press(40, 2, "press3");

    tick(1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_sys",        bus.sys_reset_n,  1'b0);
    check("arst_core",       bus.core_reset_n, 1'b0);
    check("arst_state",      bus.seq_state,    S_STRETCH);
    check("arst_count",      bus.reset_count,  8'd0);
    check("arst_fast_count", fbus.reset_count, 8'd0);
    tick(3);
    release_reset(rel);
    power_on_exp(rel, "rec");
    drain(100);

    k = 0;
    for (int i = 0; i < 260; i++) begin
      press(20, k, "sat");
      k = (k >= 255) ? 255 : k + 1;
    end
    tick(2);
    check("sat_final_count", bus.reset_count, 8'd255);
    check("sat_final_state", bus.seq_state,   S_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
